md_seq_ctrl: RTL

//  Sequences the shared multi-cycle mul/div unit for the 5-bit-opcode processor.
//  - Accepts one mul/div op from decode and freezes the pipeline while the unit computes.
//  - Drives the unit's start pulses and holds its operands.
//  - Issues a single register write-back: the result to rd, or an rstatus code to r30 on exception.

---
 rtl/md_seq_ctrl_pkg.sv | 20 ++
 rtl/md_seq_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl_pkg.sv
// Shared types and constants for the mul/div sequencing controller.
// Holds the FSM state encoding, the rstatus register index and the exception codes.
package md_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] RSTATUS_MUL = 5'd4;
  localparam logic [4:0] RSTATUS_DIV = 5'd5;

  function automatic logic [4:0] rstatus_code(input logic kind_div);
    return kind_div ? RSTATUS_DIV : RSTATUS_MUL;
  endfunction

endpackage

// File: rtl/md_seq_ctrl.sv
// Sequences the shared multi-cycle mul/div unit: freezes the pipeline, drives start pulses,
// holds operands and issues exactly one regfile write-back (result to rd, or rstatus to r30).
module md_seq_ctrl
  import md_seq_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             is_mul,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       op_rd,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_rdy,
  input  logic             md_exc,
  output logic             md_start_mul,
  output logic             md_start_div,
  output logic [WIDTH-1:0] md_a,
  output logic [WIDTH-1:0] md_b,
  output logic             stall,
  output logic             wb_en,
  output logic [4:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data
);

  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_timeout;
  logic               w_done;
  logic               w_exc;

  logic               r_start_mul;
  logic               r_start_div;
  logic [WIDTH-1:0]   r_md_a;
  logic [WIDTH-1:0]   r_md_b;
  logic [4:0]         r_rd;
  logic               r_kind_div;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wb_en;
  logic [4:0]         r_wb_reg;
  logic [WIDTH-1:0]   r_wb_data;

  // Both kind bits set is an illegal decode and must not be accepted.
  assign w_accept  = (r_state == ST_IDLE) && op_valid && (is_mul ^ is_div);
  assign w_timeout = (r_cnt == CNT_W'(MAX_CYCLES - 1));
  assign w_done    = md_rdy || w_timeout;
  assign w_exc     = md_rdy ? md_exc : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_accept;
        if (w_accept) begin
          w_next = ST_START;
        end
      end
      ST_START: begin
        stall  = 1'b1;
        w_next = ST_BUSY;
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (w_done) begin
          w_next = ST_WB;
        end
      end
      ST_WB: begin
        // Pipeline advances on this edge; op_valid still names the retiring op.
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_start_mul <= 1'b0;
      r_start_div <= 1'b0;
      r_md_a      <= '0;
      r_md_b      <= '0;
      r_rd        <= '0;
      r_kind_div  <= 1'b0;
      r_cnt       <= '0;
      r_wb_en     <= 1'b0;
      r_wb_reg    <= '0;
      r_wb_data   <= '0;
    end else begin
      r_start_mul <= w_accept && is_mul;
      r_start_div <= w_accept && is_div;
      r_wb_en     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_md_a     <= op_a;
            r_md_b     <= op_b;
            r_rd       <= op_rd;
            r_kind_div <= is_div;
          end
        end
        ST_START: begin
          r_cnt <= '0;
        end
        ST_BUSY: begin
          if (w_done) begin
            if (w_exc) begin
              r_wb_en   <= 1'b1;
              r_wb_reg  <= REG_RSTATUS;
              r_wb_data <= WIDTH'(rstatus_code(r_kind_div));
            end else begin
              r_wb_en   <= (r_rd != 5'd0);
              r_wb_reg  <= r_rd;
              r_wb_data <= md_result;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign md_start_mul = r_start_mul;
  assign md_start_div = r_start_div;
  assign md_a         = r_md_a;
  assign md_b         = r_md_b;
  assign wb_en        = r_wb_en;
  assign wb_reg       = r_wb_reg;
  assign wb_data      = r_wb_data;

endmodule
